fir_mac_seq: RTL and testbench

Sequential multiply-accumulate controller for the FIR filter. Sits directly downstream of the tap-register chain: it pulses the chain's shift (STM) and load (LDX) strobes when a new sample arrives, then walks the tap multiplexer one tap per cycle and accumulates tap × coefficient. The scaled result is presented as one filtered output sample with a single-cycle valid.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_mac_seq_if.sv | 33 +++
 rtl/fir_mac_dp.sv | 65 ++++++
 rtl/fir_mac_seq.sv | 86 ++++++++
 tb/tb_fir_mac_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and width/bound helpers for the sequential FIR MAC controller.
// Optional feature macro: FIR_SAT_EN (output saturation instead of wrap).
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    MAC,
    DONE
  } state_t;

  // Accumulator wide enough that Taps full-scale products cannot overflow.
  function automatic int acc_width(int bits_x, int bits_c, int taps);
    return bits_x + bits_c + $clog2(taps);
  endfunction

  // Tap-mux select width; never narrower than one bit.
  function automatic int sel_width(int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  // Largest value representable in a bits_y-wide signed output.
  function automatic longint sat_max(int bits_y);
    return (longint'(1) << (bits_y - 1)) - 1;
  endfunction

  // Smallest value representable in a bits_y-wide signed output.
  function automatic longint sat_min(int bits_y);
    return -(longint'(1) << (bits_y - 1));
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Bus between the MAC controller and the tap-register chain / coefficient store.
// slave: the controller side; master: the chain/coefficient/consumer side.
interface fir_mac_seq_if
  import fir_pkg::*;
#(
  parameter int BitsX = 16,
  parameter int BitsC = 16,
  parameter int Taps  = 8,
  parameter int BitsY = 16
);
  localparam int SelW = sel_width(Taps);

  logic                    sample_valid;
  logic                    STM;
  logic                    LDX;
  logic [SelW-1:0]         tap_sel;
  logic signed [BitsX-1:0] tap_data;
  logic signed [BitsC-1:0] coef;
  logic signed [BitsY-1:0] y;
  logic                    y_valid;
  logic                    busy;
  logic                    ovr;

  modport slave (
    input  sample_valid, tap_data, coef,
    output STM, LDX, tap_sel, y, y_valid, busy, ovr
  );

  modport master (
    output sample_valid, tap_data, coef,
    input  STM, LDX, tap_sel, y, y_valid, busy, ovr
  );
endinterface

// File: rtl/fir_mac_dp.sv
// MAC datapath: signed multiply, full-precision accumulate, scale and narrow.
// FIR_SAT_EN defined: clamp to the output range; otherwise two's-complement wrap.
module fir_mac_dp
  import fir_pkg::*;
#(
  parameter int BitsX    = 16,
  parameter int BitsC    = 16,
  parameter int Taps     = 8,
  parameter int BitsY    = 16,
  parameter int FracBits = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_acc_en,
  input  logic                    i_y_load,
  input  logic signed [BitsX-1:0] i_tap_data,
  input  logic signed [BitsC-1:0] i_coef,
  output logic signed [BitsY-1:0] o_y
);
  localparam int ProdW = BitsX + BitsC;
  localparam int AccW  = acc_width(BitsX, BitsC, Taps);

  logic signed [ProdW-1:0] w_prod;
  logic signed [AccW-1:0]  w_acc_next;
  logic signed [AccW-1:0]  r_acc;
  logic signed [BitsY-1:0] w_y;
  logic signed [BitsY-1:0] r_y;

  assign w_prod     = i_tap_data * i_coef;
  assign w_acc_next = r_acc + AccW'(w_prod);

`ifdef FIR_SAT_EN
  localparam longint SatMax = sat_max(BitsY);
  localparam longint SatMin = sat_min(BitsY);

  logic signed [AccW-1:0] w_shift;
  assign w_shift = w_acc_next >>> FracBits;

  // Clamp the scaled sum into the output range.
  always_comb begin
    if (longint'(w_shift) > SatMax)      w_y = BitsY'(SatMax);
    else if (longint'(w_shift) < SatMin) w_y = BitsY'(SatMin);
    else                                 w_y = w_shift[BitsY-1:0];
  end
`else
  assign w_y = BitsY'(w_acc_next >>> FracBits);
`endif

  // Accumulator: cleared before each sample, adds one product per MAC cycle.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst)          r_acc <= '0;
    else if (i_clr)    r_acc <= '0;
    else if (i_acc_en) r_acc <= w_acc_next;
  end

  // Output register: loaded with the finished sum as the last product lands.
  always_ff @(posedge clk) begin
    if (!rst)          r_y <= '0;
    else if (i_y_load) r_y <= w_y;
  end

  assign o_y = r_y;
endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR MAC controller: strobes the tap chain, walks the taps,
// and emits one scaled output sample per accepted input sample.
// Optional feature macro: FIR_SAT_EN (handled in fir_mac_dp).
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int BitsX    = 16,
  parameter int BitsC    = 16,
  parameter int Taps     = 8,
  parameter int BitsY    = 16,
  parameter int FracBits = 15
) (
  input  logic         clk,
  input  logic         rst,
  fir_mac_seq_if.slave io_bus
);
  localparam int              SelW    = sel_width(Taps);
  localparam logic [SelW-1:0] LastTap = SelW'(Taps - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [SelW-1:0] r_cnt;
  logic            r_ovr;
  logic            w_mac;
  logic            w_last;

  assign w_mac  = (r_state == MAC);
  assign w_last = w_mac && (r_cnt == LastTap);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; only IDLE looks at sample_valid.
  // NOTE: default assigned first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.sample_valid) w_state_next = SHIFT;
      SHIFT:   w_state_next = LOAD;
      LOAD:    w_state_next = MAC;
      MAC:     if (r_cnt == LastTap) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Tap counter: zeroed in LOAD, advances once per MAC cycle.
  always_ff @(posedge clk) begin
    if (!rst)                 r_cnt <= '0;
    else if (r_state == LOAD) r_cnt <= '0;
    else if (w_mac)           r_cnt <= (r_cnt == LastTap) ? '0 : r_cnt + 1'b1;
  end

  // Sticky overrun: any sample offered outside IDLE is lost.
  always_ff @(posedge clk) begin
    if (!rst)                                         r_ovr <= 1'b0;
    else if (io_bus.sample_valid && r_state != IDLE) r_ovr <= 1'b1;
  end

  assign io_bus.STM     = (r_state == SHIFT);
  assign io_bus.LDX     = (r_state == LOAD);
  assign io_bus.y_valid = (r_state == DONE);
  assign io_bus.busy    = (r_state != IDLE);
  assign io_bus.ovr     = r_ovr;
  assign io_bus.tap_sel = w_mac ? r_cnt : '0;

  fir_mac_dp #(
    .BitsX   (BitsX),
    .BitsC   (BitsC),
    .Taps    (Taps),
    .BitsY   (BitsY),
    .FracBits(FracBits)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == LOAD),
    .i_acc_en  (w_mac),
    .i_y_load  (w_last),
    .i_tap_data(io_bus.tap_data),
    .i_coef    (io_bus.coef),
    .o_y       (io_bus.y)
  );
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq with Taps=4. Cycle 0 is the cycle in which
// sample_valid is presented; cycle n is the n-th clock period after that.
module tb_fir_mac_seq;
  localparam int BitsX = 16;
  localparam int BitsC = 16;
  localparam int Taps  = 4;
  localparam int BitsY = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic signed [BitsX-1:0] m_tap  [Taps];
  logic signed [BitsC-1:0] m_coef [Taps];

  fir_mac_seq_if #(.BitsX(BitsX), .BitsC(BitsC), .Taps(Taps), .BitsY(BitsY)) bus ();

  fir_mac_seq #(
    .BitsX(BitsX), .BitsC(BitsC), .Taps(Taps), .BitsY(BitsY), .FracBits(15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  // Model of the tap mux and coefficient ROM.
  always_comb begin
    bus.tap_data = m_tap[bus.tap_sel];
    bus.coef     = m_coef[bus.tap_sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [15:0] t0, t1, t2, t3, c0, c1, c2, c3);
    m_tap[0] = t0;  m_tap[1] = t1;  m_tap[2] = t2;  m_tap[3] = t3;
    m_coef[0] = c0; m_coef[1] = c1; m_coef[2] = c2; m_coef[3] = c3;
  endtask

  task automatic test_reset();
    logic [22:0] act;
    rst = 1'b0;
    repeat (3) tick();
    act = {bus.y, bus.y_valid, bus.STM, bus.LDX, bus.busy, bus.ovr, bus.tap_sel};
    n_tests++;
    if (act !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h, want 0", act);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_strobe_order();
    logic [5:0] act, exp;
    set_vec(16'h7FFF, 0, 0, 0, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.sample_valid = 1'b0;
      act = {bus.STM, bus.LDX, bus.busy, bus.y_valid, bus.tap_sel};
      exp = {c == 1, c == 2, (c >= 1 && c <= 7), c == 7,
             (c >= 3 && c <= 6) ? 2'(c - 3) : 2'd0};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL strobe_order cycle %0d: got STM,LDX,busy,y_valid,sel=%b, want %b", c, act, exp);
      end
    end
  endtask

  task automatic test_impulse();
    set_vec(16'h7FFF, 0, 0, 0, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (bus.y_valid !== 1'b1 || bus.y !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL impulse: got y_valid=%b y=%h, want 1 3fff", bus.y_valid, bus.y);
    end
    tick();
    n_tests++;
    if (bus.y_valid !== 1'b0 || bus.y !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL impulse_hold: got y_valid=%b y=%h, want 0 3fff", bus.y_valid, bus.y);
    end
  endtask

  task automatic test_saturation();
    longint     sum;
    logic [15:0] exp;
    sum = 4 * 64'sh3FFF0001;
`ifdef FIR_SAT_EN
    exp = 16'h7FFF;
`else
    exp = 16'(sum >>> 15);
`endif
    set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (bus.y !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL sat_y_held_before_valid: got %h, want 3fff", bus.y);
    end
    tick();
    n_tests++;
    if (bus.y_valid !== 1'b1 || bus.y !== exp) begin
      n_fail++;
      $display("FAIL saturation: got y_valid=%b y=%h, want 1 %h", bus.y_valid, bus.y, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // 0x0A00 * 0.5 = 0x0500; then -0x0100 * 0.5 = -0x0080.
    set_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      bus.sample_valid = 1'b0;
      n_tests++;
      if (bus.y_valid !== (c == 7 || c == 15)) begin
        n_fail++;
        $display("FAIL b2b_y_valid cycle %0d: got %b", c, bus.y_valid);
      end
      if (c == 7 || c == 15) begin
        n_tests++;
        if (bus.y !== ((c == 7) ? 16'h0500 : 16'hFF80)) begin
          n_fail++;
          $display("FAIL b2b_y cycle %0d: got %h, want %h", c, bus.y,
                   (c == 7) ? 16'h0500 : 16'hFF80);
        end
      end
      if (c == 8) begin
        set_vec(16'hFF00, 0, 0, 0, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        bus.sample_valid = 1'b1;
      end
    end
    n_tests++;
    if (bus.ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovr: got %b, want 0", bus.ovr);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    pulses = 0;
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.sample_valid = (c == 3);
      if (bus.y_valid === 1'b1) pulses++;
      n_tests++;
      if (bus.ovr !== (c >= 4)) begin
        n_fail++;
        $display("FAIL overrun_ovr cycle %0d: got %b, want %b", c, bus.ovr, c >= 4);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL overrun_results: got %0d y_valid pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [22:0] act;
    int pulses;
    pulses = 0;
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.sample_valid = 1'b0;
      if (c == 5) begin
        act = {bus.y, bus.y_valid, bus.STM, bus.LDX, bus.busy, bus.ovr, bus.tap_sel};
        n_tests++;
        if (act !== 23'd0) begin
          n_fail++;
          $display("FAIL reset_mid_mac: got %h, want 0", act);
        end
        rst = 1'b1;
      end
      if (c > 5 && (bus.y_valid !== 1'b0 || bus.busy !== 1'b0)) pulses++;
      if (c == 4) rst = 1'b0;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_no_result: got %0d active cycles after reset, want 0", pulses);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_strobe_order();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_overrun();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
